zigzag_block_streamer: RTL and testbench
========================================

ZIGZAG_BLOCK_STREAMER -- requirements
Module: zigzag_block_streamer

Interface
REQ-001 Parameter: WIN, 16, width of one coefficient in bits; all row and coefficient widths derive from it.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 coef_tdata  in  WIN  one coefficient, delivered in zigzag scan order.
REQ-006 coef_tvalid  in  1  coef_tdata valid.
REQ-007 coef_tlast  in  1  final coefficient of the current block (end-of-block).
REQ-008 coef_tready  out  1  block accepts a coefficient.
REQ-009 master_tdata  out  WIN*8  one row of 8 natural-order coefficients.
REQ-010 master_tvalid  out  1  master_tdata valid.
REQ-011 master_tlast  out  1  high with row 7 of each block.
REQ-012 master_tready  in  1  downstream (8x8 transform wrapper slave port) accepts the row.

Function
REQ-013 Two 64-entry coefficient banks (ping-pong); each bank SHALL be in state EMPTY, FILLING or FULL, plus a 64-bit written-mask per bank.
REQ-014 Write side: pointer wbank, scan index widx 0..63; coef_tready = 1 iff bank[wbank] is EMPTY or FILLING.
REQ-015 Coefficient handshake (coef_tvalid && coef_tready): store coef_tdata at natural position ZZ[widx] of bank[wbank], set mask bit, widx+1; bank EMPTY->FILLING on first accepted coefficient, mask cleared on that same edge before the bit is set.
REQ-016 ZZ SHALL be the standard JPEG zigzag table (ZZ[0..9] = 0,1,8,16,9,2,3,10,17,24 ... ZZ[63]=63).
REQ-017 Block completion: handshake with coef_tlast=1 or widx=63; bank -> FULL, widx -> 0, wbank toggles, all on that edge.
REQ-018 Early end-of-block: positions whose mask bit is clear SHALL read as zero on master_tdata; no clearing cycles are spent.
REQ-019 Read side: pointer rbank, row counter row 0..7; master_tvalid = 1 iff bank[rbank] is FULL.
REQ-020 master_tdata row r: natural coefficient r*8+c at bits [WIN*(c+1)-1 : WIN*c], c=0..7 (column 0 in LSBs); 0 when master_tvalid=0.
REQ-021 Row handshake (master_tvalid && master_tready): row+1; on row 7, bank[rbank] -> EMPTY, row -> 0, rbank toggles.
REQ-022 master_tdata/master_tlast SHALL stay stable while master_tvalid=1 and master_tready=0.
REQ-023 Latency: completing handshake at edge N -> master_tvalid=1 after edge N (visible cycle N+1) if bank was not already queued behind the other bank.
REQ-024 Throughput: with master_tready=1 constantly, blocks stream back-to-back with no coef_tready deassertion (64 in-cycles vs 8 out-cycles).
REQ-025 Both banks FULL: coef_tready=0; bank freed at edge N -> coef_tready=1 from cycle N+1 (registered state, no combinational tready path from master_tready).
REQ-026 Simultaneous write-complete into one bank and read-free of the other on the same edge SHALL both take effect.
REQ-027 coef_tlast with widx=0 SHALL produce a block with coefficient 0 = coef_tdata and 63 zeros.
REQ-028 coef_tdata stored as-is, no sign or width conversion.

Reset
REQ-029 On reset: both banks EMPTY, masks 0, wbank=rbank=0, widx=0, row=0; outputs coef_tready=1, master_tvalid=0, master_tlast=0, master_tdata=0.
REQ-030 Reset mid-block (filling or sending) SHALL discard all partial and queued blocks; no row is emitted after reset deasserts until a new block completes.

Verification
REQ-031 Scan 64 coefs, value k at index k, master_tready=1 -> rows 0..7; row 0 cols = 0,1,5,6,14,15,27,28; master_tlast on row 7 only; master_tvalid one cycle after last coef.
REQ-032 Block with tlast at index 2 (values 7,3,5) -> natural pos 0=7, 1=3, 8=5, other 61 entries 0; next block's unwritten entries also 0.
REQ-033 Three back-to-back blocks, master_tready=0 -> after 128 coefs coef_tready=0; raise master_tready, after 8 row handshakes coef_tready=1 next cycle; blocks emerge in order.
REQ-034 Random master_tready toggling -> master_tdata stable under stall; every row matches model, no loss or duplication over 100 blocks.
REQ-035 Assert reset during row 3 of a block with second block queued -> master_tvalid=0 immediately, coef_tready=1; next completed block emitted from row 0 correctly.
REQ-036 Single tlast coef (value 0x1234) -> row 0 = 0x1234 in LSB lane, all other lanes/rows 0.

Source files
------------

// File: rtl/zigzag_block_streamer.sv
// ---------------------------------------------------------------------------
// zigzag_block_streamer
//
// Purpose: collects 8x8 blocks of coefficients arriving in JPEG zigzag scan
// order and emits them as natural-order rows of 8 coefficients. Two 64-entry
// banks are used ping-pong so one block can fill while the other drains.
// Positions that were never written in a block (early end-of-block) read as
// zero through a per-bank written-mask, so no clearing cycles are needed.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous, active-high; discards all blocks
//   coef_tdata     one coefficient (WIN bits), zigzag scan order
//   coef_tvalid    coef_tdata valid
//   coef_tlast     final coefficient of the current block
//   coef_tready    a bank is available to accept coefficients
//   master_tdata   one row of 8 natural-order coefficients, column 0 in LSBs
//   master_tvalid  a full bank is being presented
//   master_tlast   high with row 7 of each block
//   master_tready  downstream accepts the row
// ---------------------------------------------------------------------------
module zigzag_block_streamer #(
   parameter int WIN = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIN-1:0]   coef_tdata,
   input  logic             coef_tvalid,
   input  logic             coef_tlast,
   output logic             coef_tready,
   output logic [WIN*8-1:0] master_tdata,
   output logic             master_tvalid,
   output logic             master_tlast,
   input  logic             master_tready
);

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   // Scan index -> natural (row*8+col) position.
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic       wbank_reg;
   logic       rbank_reg;
   logic [5:0] widx_reg;
   logic [2:0] row_reg;

   logic [1:0]                bank_full;
   logic [1:0][WIN*8-1:0]     bank_row;

   logic       coef_hs;
   logic       coef_done;
   logic       row_hs;
   logic       row_free;
   logic [5:0] wpos;

   // Both ready and valid come purely from registered bank state, so there is
   // no combinational path from master_tready to coef_tready.
   assign coef_tready   = !bank_full[wbank_reg];
   assign master_tvalid = bank_full[rbank_reg];
   assign master_tlast  = master_tvalid && (row_reg == 3'd7);
   assign master_tdata  = master_tvalid ? bank_row[rbank_reg] : '0;

   assign coef_hs   = coef_tvalid && coef_tready;
   assign coef_done = coef_hs && (coef_tlast || (widx_reg == 6'd63));
   assign row_hs    = master_tvalid && master_tready;
   assign row_free  = row_hs && (row_reg == 3'd7);
   assign wpos      = ZZ[widx_reg];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         localparam logic BANK_ID = (gi == 1);

         bank_state_t    state_reg;
         logic [63:0]    mask_reg;
         logic [WIN-1:0] mem_reg [64];
         logic [WIN*8-1:0] row_data;
         logic           wr_sel;
         logic           rd_free_sel;

         assign wr_sel      = coef_hs  && (wbank_reg == BANK_ID);
         assign rd_free_sel = row_free && (rbank_reg == BANK_ID);
         assign bank_full[gi] = (state_reg == BANK_FULL);
         assign bank_row[gi]  = row_data;

         // A bank being written is never FULL and a bank being freed is
         // always FULL, so the two updates never target the same bank.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               state_reg <= BANK_EMPTY;
               mask_reg  <= '0;
            end else if (wr_sel) begin
               // First coefficient of a block discards the previous mask.
               mask_reg  <= ((state_reg == BANK_EMPTY) ? 64'd0 : mask_reg) |
                            (64'd1 << wpos);
               state_reg <= coef_done ? BANK_FULL : BANK_FILLING;
            end else if (rd_free_sel) begin
               state_reg <= BANK_EMPTY;
            end
         end

         // Coefficient storage needs no reset: unwritten entries are hidden
         // by the mask.
         always_ff @(posedge clock) begin
            if (wr_sel) begin
               mem_reg[wpos] <= coef_tdata;
            end
         end

         // All 8 lanes of the current row are read in parallel.
         for (genvar ci = 0; ci < 8; ci++) begin : g_lane
            assign row_data[WIN*ci +: WIN] =
               mask_reg[{row_reg, 3'(ci)}] ? mem_reg[{row_reg, 3'(ci)}] : '0;
         end
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wbank_reg <= 1'b0;
         rbank_reg <= 1'b0;
         widx_reg  <= '0;
         row_reg   <= '0;
      end else begin
         if (coef_done) begin
            widx_reg  <= '0;
            wbank_reg <= ~wbank_reg;
         end else if (coef_hs) begin
            widx_reg  <= widx_reg + 6'd1;
         end
         if (row_hs) begin
            row_reg <= row_reg + 3'd1;   // wraps 7 -> 0
            if (row_reg == 3'd7) begin
               rbank_reg <= ~rbank_reg;
            end
         end
      end
   end

endmodule

// File: tb/tb_zigzag_block_streamer.sv
module tb_zigzag_block_streamer;
   localparam int WIN = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [WIN-1:0]   coef_tdata = '0;
   logic             coef_tvalid = 1'b0;
   logic             coef_tlast = 1'b0;
   logic             coef_tready;
   logic [WIN*8-1:0] master_tdata;
   logic             master_tvalid;
   logic             master_tlast;
   logic             master_tready = 1'b0;

   int checks = 0;
   int failures = 0;
   int mode = 0;   // 0: downstream always ready, 1: never ready, 2: random

   zigzag_block_streamer #(.WIN(WIN)) dut (
      .clock(clock), .reset(reset),
      .coef_tdata(coef_tdata), .coef_tvalid(coef_tvalid),
      .coef_tlast(coef_tlast), .coef_tready(coef_tready),
      .master_tdata(master_tdata), .master_tvalid(master_tvalid),
      .master_tlast(master_tlast), .master_tready(master_tready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [WIN*8-1:0] got,
                      input logic [WIN*8-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int             zz [64];          // scan index -> natural position
   logic [WIN-1:0] qmem [$];         // completed blocks, 64 entries each, natural order
   logic [WIN-1:0] part [64];        // block being assembled
   int             widx_m;
   int             row_m;

   // Walk the anti-diagonals of the 8x8 grid, alternating direction.
   initial begin
      int k;
      k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo, hi;
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
         end
      end
   end

   function automatic logic [WIN*8-1:0] model_row();
      logic [WIN*8-1:0] r;
      r = '0;
      for (int c = 0; c < 8; c++) r[c*WIN +: WIN] = qmem[row_m*8 + c];
      return r;
   endfunction

   task automatic model_clear();
      qmem.delete();
      foreach (part[i]) part[i] = '0;
      widx_m = 0;
      row_m  = 0;
   endtask

   logic             prev_stall = 1'b0;
   logic [WIN*8-1:0] prev_data;
   logic             prev_last;

   // Single compare process: outputs are checked mid-cycle, then the model
   // advances by the handshakes that the next rising edge will perform.
   always @(negedge clock) begin
      if (reset) begin
         model_clear();
         prev_stall = 1'b0;
         chk("reset_tvalid", master_tvalid, 0);
         chk("reset_tlast",  master_tlast, 0);
         chk("reset_tdata",  master_tdata, 0);
         chk("reset_ready",  coef_tready, 1);
      end else begin
         int  nblk;
         logic exp_valid, exp_ready;
         nblk      = qmem.size() / 64;
         exp_valid = (nblk > 0);
         exp_ready = (nblk < 2);
         chk("tvalid", master_tvalid, exp_valid);
         chk("coef_tready", coef_tready, exp_ready);
         chk("tdata", master_tdata, exp_valid ? model_row() : '0);
         chk("tlast", master_tlast, exp_valid && row_m == 7);
         if (prev_stall) begin
            chk("stall_tdata", master_tdata, prev_data);
            chk("stall_tlast", master_tlast, prev_last);
         end
         prev_stall = master_tvalid && !master_tready;
         prev_data  = master_tdata;
         prev_last  = master_tlast;

         if (exp_valid && master_tready) begin
            row_m++;
            if (row_m == 8) begin
               row_m = 0;
               repeat (64) void'(qmem.pop_front());
            end
         end
         if (exp_ready && coef_tvalid) begin
            part[zz[widx_m]] = coef_tdata;
            widx_m++;
            if (coef_tlast || widx_m == 64) begin
               for (int i = 0; i < 64; i++) qmem.push_back(part[i]);
               foreach (part[i]) part[i] = '0;
               widx_m = 0;
            end
         end
      end
   end

   // Downstream ready pattern, applied 2 time units after each edge.
   always @(posedge clock) begin
      #2;
      case (mode)
         0:       master_tready = 1'b1;
         1:       master_tready = 1'b0;
         default: master_tready = 1'($urandom_range(1));
      endcase
   end

   // ---------------- stimulus ----------------
   logic [WIN-1:0] blkv [64];

   task automatic send_coef(input logic [WIN-1:0] d, input logic last);
      int  n;
      bit  ok;
      n = 0;
      coef_tdata  = d;
      coef_tlast  = last;
      coef_tvalid = 1'b1;
      forever begin
         @(negedge clock);
         ok = coef_tready;
         @(posedge clock);
         #1;
         if (ok) break;
         n++;
         if (n > 3000) begin
            checks++; failures++;
            $display("FAIL coef_handshake_timeout: got no handshake, required one within 3000 cycles");
            break;
         end
      end
      coef_tvalid = 1'b0;
      coef_tlast  = 1'b0;
   endtask

   task automatic send_block(input int len, input bit last_at_end, input bit gaps);
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(3) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
         end
         send_coef(blkv[i], (i == len - 1) && last_at_end);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (qmem.size() != 0 && n < 3000) begin @(posedge clock); #1; n++; end
      if (qmem.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout: got %0d entries pending, required 0", qmem.size());
      end
      repeat (2) begin @(posedge clock); #1; end
   endtask

   task automatic random_fill();
      for (int i = 0; i < 64; i++) blkv[i] = WIN'($urandom);
   endtask

   initial begin
      logic [WIN*8-1:0] lit;
      int len;

      mode = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock); #1;

      // Ramp block: value k at scan index k, 64 coefficients, no tlast.
      for (int i = 0; i < 64; i++) blkv[i] = WIN'(i);
      send_block(64, 1'b0, 1'b0);
      chk("ramp_latency_tvalid", master_tvalid, 1);
      lit = {16'd28, 16'd27, 16'd15, 16'd14, 16'd6, 16'd5, 16'd1, 16'd0};
      chk("ramp_row0", master_tdata, lit);
      drain();

      // Early end-of-block at scan index 2, held on row 0 while stalled.
      mode = 1;
      blkv[0] = 16'd7; blkv[1] = 16'd3; blkv[2] = 16'd5;
      send_block(3, 1'b1, 1'b0);
      lit = {96'd0, 16'd3, 16'd7};
      chk("short_row0", master_tdata, lit);
      random_fill();
      send_block(4, 1'b1, 1'b0);   // next block: unwritten entries must be 0
      mode = 0;
      drain();

      // Single tlast coefficient.
      blkv[0] = 16'h1234;
      send_block(1, 1'b1, 1'b0);
      lit = {112'd0, 16'h1234};
      chk("single_row0", master_tdata, lit);
      drain();

      // Three back-to-back blocks with downstream stalled.
      mode = 1;
      random_fill(); send_block(64, 1'b1, 1'b0);
      random_fill(); send_block(64, 1'b0, 1'b0);
      chk("both_full_ready", coef_tready, 0);
      random_fill();
      fork
         send_block(64, 1'b1, 1'b0);
         begin repeat (5) @(posedge clock); #1 mode = 0; end
      join
      drain();

      // Random lengths, gaps and downstream back-pressure over 100 blocks.
      mode = 2;
      for (int b = 0; b < 100; b++) begin
         random_fill();
         len = $urandom_range(1, 64);
         send_block(len, (len < 64) ? 1'b1 : 1'($urandom_range(1)), 1'b1);
      end
      mode = 0;
      drain();

      // Reset during row 3 with a second block queued.
      mode = 1;
      random_fill(); send_block(64, 1'b1, 1'b0);
      random_fill(); send_block(64, 1'b1, 1'b0);
      mode = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("pre_reset_tvalid", master_tvalid, 1);
      reset = 1'b1;
      #1;
      chk("reset_mid_tvalid", master_tvalid, 0);
      chk("reset_mid_ready", coef_tready, 1);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (10) begin @(posedge clock); #1; end
      for (int i = 0; i < 64; i++) blkv[i] = WIN'(i);
      send_block(64, 1'b1, 1'b0);
      lit = {16'd28, 16'd27, 16'd15, 16'd14, 16'd6, 16'd5, 16'd1, 16'd0};
      chk("post_reset_row0", master_tdata, lit);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
